// File: rtl/rv32i_core_ctrl.sv
// Multi-cycle sequencer for the RV32I datapath: owns PC/IR, steps the core state
// machine, drives fetch/data handshakes and rf_we, and implements debug run-control.
module rv32i_core_ctrl #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] instr,
   output logic [31:0] pc,
   input  logic        ctrl_mem_read,
   input  logic        ctrl_mem_write,
   input  logic        ctrl_reg_write,
   input  logic        ctrl_is_ebreak,
   input  logic        br_taken,
   input  logic [31:0] br_target,
   output logic        dmem_req,
   input  logic        dmem_ready,
   output logic        rf_we,
   input  logic        dbg_halt_req,
   input  logic        dbg_resume_req,
   input  logic        dbg_step_req,
   input  logic        dbg_bp_hit,
   input  logic        dbg_pc_we,
   input  logic [31:0] dbg_pc_wdata,
   output logic        halted,
   output logic [3:0]  halt_cause,
   output logic [2:0]  state,
   output logic [31:0] instret
);

   typedef enum logic [2:0] {
      CPU_RESET     = 3'd0,
      CPU_FETCH     = 3'd1,
      CPU_DECODE    = 3'd2,
      CPU_EXECUTE   = 3'd3,
      CPU_MEM_WAIT  = 3'd4,
      CPU_WRITEBACK = 3'd5,
      CPU_HALTED    = 3'd6,
      CPU_STEP      = 3'd7
   } cpu_state_e;

   typedef enum logic [3:0] {
      HALT_NONE       = 4'd0,
      HALT_REQUEST    = 4'd1,
      HALT_BREAKPOINT = 4'd2,
      HALT_STEP       = 4'd3,
      HALT_EBREAK     = 4'd4
   } halt_cause_e;

   cpu_state_e  state_q, state_d;
   halt_cause_e cause_q, cause_d;
   logic        step_mode, bp_skip, fetch_pend;
   logic        fetch_halt;

   // Once a fetch is outstanding it must complete; debug stops only between fetches.
   assign fetch_halt = !fetch_pend && (dbg_halt_req || (dbg_bp_hit && !bp_skip));

   assign state      = state_q;
   assign halt_cause = cause_q;
   assign imem_addr  = pc;

   // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= CPU_RESET;
         cause_q <= HALT_NONE;
      end else begin
         state_q <= state_d;
         cause_q <= cause_d;
      end
   end

   // NOTE: defaults first so no path through the case leaves a variable unassigned (no latches).
   always_comb begin
      state_d = state_q;
      cause_d = cause_q;
      unique case (state_q)
         CPU_RESET:  state_d = CPU_FETCH;
         CPU_FETCH: begin
            if (fetch_halt) begin
               state_d = CPU_HALTED;
               cause_d = dbg_halt_req ? HALT_REQUEST : HALT_BREAKPOINT;
            end else if (imem_ready) begin
               state_d = CPU_DECODE;
            end
         end
         CPU_DECODE: state_d = CPU_EXECUTE;
         CPU_EXECUTE: begin
            if (ctrl_is_ebreak) begin
               state_d = CPU_HALTED;
               cause_d = HALT_EBREAK;
            end else if (ctrl_mem_read || ctrl_mem_write) begin
               state_d = CPU_MEM_WAIT;
            end else begin
               state_d = CPU_WRITEBACK;
            end
         end
         CPU_MEM_WAIT: if (dmem_ready) state_d = CPU_WRITEBACK;
         CPU_WRITEBACK: begin
            if (step_mode) begin
               state_d = CPU_HALTED;
               cause_d = HALT_STEP;
            end else begin
               state_d = CPU_FETCH;
            end
         end
         CPU_HALTED: begin
            if (dbg_step_req) begin
               state_d = CPU_STEP;
            end else if (dbg_resume_req) begin
               state_d = CPU_FETCH;
               cause_d = HALT_NONE;
            end
         end
         CPU_STEP: begin
            state_d = CPU_FETCH;
            cause_d = HALT_NONE;
         end
         default: state_d = CPU_RESET;
      endcase
   end

   always_comb begin
      imem_req = (state_q == CPU_FETCH) && !fetch_halt;
      dmem_req = (state_q == CPU_MEM_WAIT);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc         <= RESET_PC;
         instr      <= NOP_INSTR;
         instret    <= 32'd0;
         halted     <= 1'b0;
         rf_we      <= 1'b0;
         step_mode  <= 1'b0;
         bp_skip    <= 1'b0;
         fetch_pend <= 1'b0;
      end else begin
         halted <= (state_d == CPU_HALTED);
         rf_we  <= (state_d == CPU_WRITEBACK) && ctrl_reg_write;

         if ((state_q == CPU_FETCH) && imem_req) begin
            fetch_pend <= !imem_ready;
            if (imem_ready) begin
               instr   <= imem_rdata;
               bp_skip <= 1'b0;
            end
         end

         unique case (state_q)
            CPU_WRITEBACK: begin
               pc      <= br_taken ? (br_target & ~32'h3) : pc + 32'd4;
               instret <= instret + 32'd1;
            end
            CPU_HALTED: begin
               if (dbg_pc_we) pc <= dbg_pc_wdata;
               if (!dbg_step_req && dbg_resume_req) bp_skip <= 1'b1;
            end
            CPU_STEP: begin
               step_mode <= 1'b1;
               bp_skip   <= 1'b1;
            end
            default: ;
         endcase

         if (state_d == CPU_HALTED) step_mode <= 1'b0;
      end
   end

endmodule

// File: tb/tb_rv32i_core_ctrl.sv
// Bench for rv32i_core_ctrl: directed table, debug run-control sequences, and random
// instruction streams checked against an instruction-level PC/instret model.
module tb_rv32i_core_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        ctrl_mem_read, ctrl_mem_write, ctrl_reg_write, ctrl_is_ebreak;
   logic        br_taken;
   logic [31:0] br_target;
   logic        dmem_req, dmem_ready, rf_we;
   logic        dbg_halt_req, dbg_resume_req, dbg_step_req, dbg_bp_hit, dbg_pc_we;
   logic [31:0] dbg_pc_wdata;
   logic        halted;
   logic [3:0]  halt_cause;
   logic [2:0]  state;
   logic [31:0] instret;

   rv32i_core_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instr(instr), .pc(pc),
      .ctrl_mem_read(ctrl_mem_read), .ctrl_mem_write(ctrl_mem_write),
      .ctrl_reg_write(ctrl_reg_write), .ctrl_is_ebreak(ctrl_is_ebreak),
      .br_taken(br_taken), .br_target(br_target),
      .dmem_req(dmem_req), .dmem_ready(dmem_ready), .rf_we(rf_we),
      .dbg_halt_req(dbg_halt_req), .dbg_resume_req(dbg_resume_req),
      .dbg_step_req(dbg_step_req), .dbg_bp_hit(dbg_bp_hit),
      .dbg_pc_we(dbg_pc_we), .dbg_pc_wdata(dbg_pc_wdata),
      .halted(halted), .halt_cause(halt_cause), .state(state), .instret(instret)
   );

   always #5 clk = ~clk;

   localparam logic [31:0] S_RESET = 0, S_FETCH = 1, S_DECODE = 2, S_EXEC = 3,
                           S_MEM = 4, S_WB = 5, S_HALTED = 6, S_STEP = 7;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      int          fwait;
      int          mwait;
      bit          is_mem;
      bit          rw;
      bit          taken;
      logic [31:0] target;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t        vecs[7];
   int          n_checks = 0;
   int          n_passed = 0;
   logic [31:0] model_pc;
   logic [31:0] model_instret;
   bit          halt_in_stall = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
      else n_passed++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one non-EBREAK instruction from its FETCH cycle to the cycle after WRITEBACK.
   task automatic run_instr(input string nm, input logic [31:0] rdata, input int fwait,
                            input int mwait, input bit is_mem, input bit rw, input bit taken,
                            input logic [31:0] target, input bit stepping);
      check({nm, " fetch state"}, 32'(state), S_FETCH);
      check({nm, " imem_addr"}, imem_addr, model_pc);
      imem_rdata = rdata;
      for (int w = 0; w <= fwait; w++) begin
         check({nm, " imem_req"}, 32'(imem_req), 32'd1);
         imem_ready = (w == fwait);
         tick();
         if (w == 0 && halt_in_stall) begin
            dbg_halt_req = 1'b1;
            #1;
         end
      end
      imem_ready = 1'b0;
      check({nm, " decode state"}, 32'(state), S_DECODE);
      check({nm, " instr"}, instr, rdata);
      tick();
      check({nm, " execute state"}, 32'(state), S_EXEC);
      ctrl_mem_read  = is_mem && rw;
      ctrl_mem_write = is_mem && !rw;
      ctrl_reg_write = rw;
      tick();
      ctrl_mem_read  = 1'b0;
      ctrl_mem_write = 1'b0;
      if (is_mem) begin
         for (int k = 0; k < mwait; k++) begin
            check({nm, " mem_wait state/dmem_req"}, 32'({state, dmem_req}), {S_MEM[28:0], 1'b1});
            dmem_ready = (k == mwait - 1);
            tick();
         end
         dmem_ready = 1'b0;
      end
      check({nm, " writeback state"}, 32'(state), S_WB);
      check({nm, " rf_we"}, 32'(rf_we), 32'(rw));
      check({nm, " dmem_req in wb"}, 32'(dmem_req), 32'd0);
      br_taken  = taken;
      br_target = target;
      tick();
      br_taken       = 1'b0;
      ctrl_reg_write = 1'b0;
      model_pc       = taken ? {target[31:2], 2'b00} : model_pc + 32'd4;
      model_instret  = model_instret + 32'd1;
      check({nm, " pc"}, pc, model_pc);
      check({nm, " instret"}, instret, model_instret);
      check({nm, " rf_we after wb"}, 32'(rf_we), 32'd0);
      check({nm, " next state"}, 32'(state), stepping ? S_HALTED : S_FETCH);
   endtask

   task automatic check_reset_values(input string nm);
      check({nm, " state"}, 32'(state), S_RESET);
      check({nm, " pc"}, pc, 32'h0);
      check({nm, " instr"}, instr, 32'h0000_0013);
      check({nm, " instret"}, instret, 32'h0);
      check({nm, " halt_cause/halted"}, 32'({halt_cause, halted}), 32'h0);
      check({nm, " req/we"}, 32'({imem_req, dmem_req, rf_we}), 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0;
      imem_ready = 0; imem_rdata = 0; ctrl_mem_read = 0; ctrl_mem_write = 0;
      ctrl_reg_write = 0; ctrl_is_ebreak = 0; br_taken = 0; br_target = 0; dmem_ready = 0;
      dbg_halt_req = 0; dbg_resume_req = 0; dbg_step_req = 0; dbg_bp_hit = 0;
      dbg_pc_we = 0; dbg_pc_wdata = 0;

      vecs[0] = '{"addi",      32'h0050_0093, 0, 0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0004};
      vecs[1] = '{"lw",        32'h0000_2103, 0, 4, 1'b1, 1'b1, 1'b0, 32'h0,         32'h0000_0008};
      vecs[2] = '{"sw",        32'h0011_2023, 1, 1, 1'b1, 1'b0, 1'b0, 32'h0,         32'h0000_000C};
      vecs[3] = '{"beq taken", 32'h0000_0463, 0, 0, 1'b0, 1'b0, 1'b1, 32'h0000_0102, 32'h0000_0100};
      vecs[4] = '{"addi stall",32'h0010_0113, 2, 0, 1'b0, 1'b1, 1'b0, 32'h0,         32'h0000_0104};
      vecs[5] = '{"jal",       32'h0000_006F, 0, 0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
      vecs[6] = '{"wrap",      32'h0000_0013, 0, 0, 1'b0, 1'b0, 1'b0, 32'h0,         32'h0000_0000};

      repeat (2) @(posedge clk);
      #1;
      check_reset_values("reset");
      rst_n = 1'b1;
      #1;
      check("reset state held", 32'(state), S_RESET);
      tick();
      model_pc = 32'h0;
      model_instret = 32'h0;

      for (int i = 0; i < 7; i++) begin
         run_instr(vecs[i].name, vecs[i].rdata, vecs[i].fwait, vecs[i].mwait, vecs[i].is_mem,
                   vecs[i].rw, vecs[i].taken, vecs[i].target, 1'b0);
         check({vecs[i].name, " table pc"}, pc, vecs[i].exp_pc);
      end
      check("instret after table", instret, 32'd7);

      run_instr("pad0", 32'h13, 0, 0, 0, 0, 0, 0, 0);
      run_instr("pad1", 32'h13, 0, 0, 0, 0, 0, 0, 0);

      // Breakpoint at 0x8, then single-step over it.
      dbg_bp_hit = 1'b1;
      #1;
      check("bp no imem_req", 32'(imem_req), 32'd0);
      tick();
      check("bp state", 32'(state), S_HALTED);
      check("bp cause/halted", 32'({halt_cause, halted}), 32'h5);
      check("bp pc", pc, 32'h8);
      dbg_step_req = 1'b1;
      tick();
      dbg_step_req = 1'b0;
      check("step state", 32'(state), S_STEP);
      check("step halted", 32'(halted), 32'd0);
      tick();
      check("step cause cleared", 32'(halt_cause), 32'd0);
      run_instr("stepped", 32'h13, 0, 0, 0, 1, 0, 0, 1);
      check("step cause", 32'({halt_cause, halted}), 32'h7);
      check("step pc", pc, 32'hC);
      dbg_bp_hit = 1'b0;
      dbg_resume_req = 1'b1;
      tick();
      dbg_resume_req = 1'b0;
      check("resume state", 32'(state), S_FETCH);
      check("resume cause", 32'(halt_cause), 32'd0);
      run_instr("pre-ebreak", 32'h13, 0, 0, 0, 1, 0, 0, 0);

      // EBREAK at 0x10, then debugger moves pc to 0x14 and resumes.
      check("ebreak imem_addr", imem_addr, 32'h10);
      imem_ready = 1'b1; imem_rdata = 32'h0010_0073;
      tick();
      imem_ready = 1'b0;
      tick();
      ctrl_is_ebreak = 1'b1;
      tick();
      ctrl_is_ebreak = 1'b0;
      check("ebreak state", 32'(state), S_HALTED);
      check("ebreak cause", 32'(halt_cause), 32'h4);
      check("ebreak pc", pc, 32'h10);
      check("ebreak instret", instret, model_instret);
      dbg_pc_we = 1'b1; dbg_pc_wdata = 32'h14;
      tick();
      dbg_pc_we = 1'b0;
      check("pc write", pc, 32'h14);
      dbg_resume_req = 1'b1;
      tick();
      dbg_resume_req = 1'b0;
      check("resume fetch addr", imem_addr, 32'h14);
      check("resume fetch req/cause", 32'({imem_req, halt_cause}), 32'h10);
      model_pc = 32'h14;

      // Halt request raised during a 3-cycle fetch stall.
      halt_in_stall = 1'b1;
      run_instr("stall halt", 32'h13, 3, 0, 0, 1, 0, 0, 0);
      halt_in_stall = 1'b0;
      check("halt no imem_req", 32'(imem_req), 32'd0);
      tick();
      check("halt req state", 32'(state), S_HALTED);
      check("halt req cause", 32'(halt_cause), 32'h1);
      dbg_halt_req = 1'b0;
      dbg_resume_req = 1'b1;
      tick();
      dbg_resume_req = 1'b0;

      // Reset asserted in the middle of MEM_WAIT.
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      tick();
      ctrl_mem_read = 1'b1;
      tick();
      ctrl_mem_read = 1'b0;
      check("mid mem state", 32'(state), S_MEM);
      #2 rst_n = 1'b0;
      #1;
      check_reset_values("reset in mem_wait");
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      model_pc = 32'h0;
      model_instret = 32'h0;

      // Random instruction stream against the instruction-level model.
      for (int n = 0; n < 40; n++) begin
         if ($urandom_range(0, 5) == 0) begin
            dbg_halt_req = 1'b1;
            #1;
            check("rand halt no req", 32'(imem_req), 32'd0);
            tick();
            dbg_halt_req = 1'b0;
            check("rand halt cause/halted", 32'({halt_cause, halted}), 32'h3);
            if ($urandom_range(0, 1) == 1) begin
               dbg_pc_we = 1'b1; dbg_pc_wdata = $urandom;
               model_pc = dbg_pc_wdata;
               tick();
               dbg_pc_we = 1'b0;
            end
            dbg_resume_req = 1'b1;
            tick();
            dbg_resume_req = 1'b0;
         end
         run_instr("rand", $urandom, $urandom_range(0, 3), $urandom_range(1, 4),
                   ($urandom_range(0, 2) == 0), $urandom_range(0, 1) == 1,
                   ($urandom_range(0, 3) == 0), $urandom, 1'b0);
      end

      $display("%0d/%0d checks passed", n_passed, n_checks);
      $finish;
   end

endmodule
